// File: rtl/simplerisc_hazard_unit.sv
// rtl/simplerisc_hazard_unit.sv - SimpleRISC hazard unit: scoreboard, forwarding selects, interlock, flush, freeze
module simplerisc_hazard_unit #(
    parameter int REG_ADDR_W   = 4,
    parameter bit R0_HARDWIRED = 1'b0,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  of_valid,
    input  logic [REG_ADDR_W-1:0] of_rs1,
    input  logic [REG_ADDR_W-1:0] of_rs2,
    input  logic [REG_ADDR_W-1:0] of_rs_st,
    input  logic                  of_uses1,
    input  logic                  of_uses2,
    input  logic                  of_uses_st,
    input  logic                  of_wb,
    input  logic [REG_ADDR_W-1:0] of_rd,
    input  logic                  of_is_ld,
    input  logic                  ex_busy,
    input  logic                  branch_taken,
    output logic                  stall_front,
    output logic                  flush_front,
    output logic                  hold_ex,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic [1:0]            fwd_op2_sel,
    output logic                  fwd_st_ma,
    output logic [CNT_W-1:0]      stall_cnt
);

    typedef logic [REG_ADDR_W-1:0] reg_t;

    typedef struct packed {
        logic v;
        reg_t rs1;
        reg_t rs2;
        reg_t rs_st;
        logic uses1;
        logic uses2;
        logic uses_st;
        logic wb;
        reg_t rd;
        logic is_ld;
    } ex_slot_t;

    typedef struct packed {
        logic v;
        logic wb;
        reg_t rd;
        logic is_ld;
        reg_t rs_st;
        logic uses_st;
    } ma_slot_t;

    typedef struct packed {
        logic v;
        logic wb;
        reg_t rd;
        logic is_ld;
    } rw_slot_t;

    ex_slot_t ex_q;
    ma_slot_t ma_q;
    rw_slot_t rw_q;
    ex_slot_t of_rec;

    logic busy;
    logic load_use;

    // A slot produces register r; r0 is excluded when it is hardwired to zero.
    function automatic logic hits(input logic v, input logic wb, input reg_t rd, input reg_t r);
        return v && wb && (rd == r) && !(R0_HARDWIRED && (r == '0));
    endfunction

    // Youngest producer wins; an MA load has no result yet and is never a source.
    function automatic logic [1:0] pick_src(input logic uses, input reg_t r,
                                            input ma_slot_t ma, input rw_slot_t rw);
        if (uses && hits(ma.v, ma.wb, ma.rd, r) && !ma.is_ld)
            return 2'b01;
        else if (uses && hits(rw.v, rw.wb, rw.rd, r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign of_rec.v       = of_valid;
    assign of_rec.rs1     = of_rs1;
    assign of_rec.rs2     = of_rs2;
    assign of_rec.rs_st   = of_rs_st;
    assign of_rec.uses1   = of_uses1;
    assign of_rec.uses2   = of_uses2;
    assign of_rec.uses_st = of_uses_st;
    assign of_rec.wb      = of_wb;
    assign of_rec.rd      = of_rd;
    assign of_rec.is_ld   = of_is_ld;

    // Gated so every output reads 0 while reset is held, even with ex_busy high.
    assign busy = rst_n && ex_busy;

    assign load_use = of_valid && ex_q.is_ld &&
                      ((of_uses1 && hits(ex_q.v, ex_q.wb, ex_q.rd, of_rs1)) ||
                       (of_uses2 && hits(ex_q.v, ex_q.wb, ex_q.rd, of_rs2)));

    assign hold_ex     = busy;
    assign flush_front = !busy && ex_q.v && branch_taken;
    assign stall_front = busy || (load_use && !flush_front);

    assign fwd_a_sel   = pick_src(ex_q.uses1,   ex_q.rs1,   ma_q, rw_q);
    assign fwd_b_sel   = pick_src(ex_q.uses2,   ex_q.rs2,   ma_q, rw_q);
    assign fwd_op2_sel = pick_src(ex_q.uses_st, ex_q.rs_st, ma_q, rw_q);

    // Store data whose producer was a load is patched in MA from the RW load result.
    assign fwd_st_ma = ma_q.v && ma_q.uses_st && rw_q.is_ld &&
                       hits(rw_q.v, rw_q.wb, rw_q.rd, ma_q.rs_st);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            ma_q      <= '0;
            rw_q      <= '0;
            stall_cnt <= '0;
        end else begin
            rw_q.v     <= ma_q.v;
            rw_q.wb    <= ma_q.wb;
            rw_q.rd    <= ma_q.rd;
            rw_q.is_ld <= ma_q.is_ld;

            if (busy) begin
                ma_q <= '0;
            end else begin
                ma_q.v       <= ex_q.v;
                ma_q.wb      <= ex_q.wb;
                ma_q.rd      <= ex_q.rd;
                ma_q.is_ld   <= ex_q.is_ld;
                ma_q.rs_st   <= ex_q.rs_st;
                ma_q.uses_st <= ex_q.uses_st;
                if (flush_front || load_use || !of_valid)
                    ex_q <= '0;
                else
                    ex_q <= of_rec;
            end

            if (stall_front && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_simplerisc_hazard_unit.sv
// tb/tb_simplerisc_hazard_unit.sv - scoreboard bench for simplerisc_hazard_unit (default and r0/2-bit-counter instances)
module tb_simplerisc_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       of_valid;
    logic [3:0] of_rs1, of_rs2, of_rs_st, of_rd;
    logic       of_uses1, of_uses2, of_uses_st, of_wb, of_is_ld;
    logic       ex_busy, branch_taken;

    logic        stall_front, flush_front, hold_ex, fwd_st_ma;
    logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_op2_sel;
    logic [15:0] stall_cnt;

    logic        h_stall_front, h_flush_front, h_hold_ex, h_fwd_st_ma;
    logic [1:0]  h_fwd_a_sel, h_fwd_b_sel, h_fwd_op2_sel;
    logic [1:0]  h_stall_cnt;

    always #5 clk = ~clk;

    simplerisc_hazard_unit dut (
        .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_rs_st(of_rs_st), .of_uses1(of_uses1), .of_uses2(of_uses2), .of_uses_st(of_uses_st),
        .of_wb(of_wb), .of_rd(of_rd), .of_is_ld(of_is_ld), .ex_busy(ex_busy),
        .branch_taken(branch_taken), .stall_front(stall_front), .flush_front(flush_front),
        .hold_ex(hold_ex), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_op2_sel(fwd_op2_sel), .fwd_st_ma(fwd_st_ma), .stall_cnt(stall_cnt)
    );

    simplerisc_hazard_unit #(.REG_ADDR_W(4), .R0_HARDWIRED(1'b1), .CNT_W(2)) dut_h (
        .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_rs1(of_rs1), .of_rs2(of_rs2),
        .of_rs_st(of_rs_st), .of_uses1(of_uses1), .of_uses2(of_uses2), .of_uses_st(of_uses_st),
        .of_wb(of_wb), .of_rd(of_rd), .of_is_ld(of_is_ld), .ex_busy(ex_busy),
        .branch_taken(branch_taken), .stall_front(h_stall_front), .flush_front(h_flush_front),
        .hold_ex(h_hold_ex), .fwd_a_sel(h_fwd_a_sel), .fwd_b_sel(h_fwd_b_sel),
        .fwd_op2_sel(h_fwd_op2_sel), .fwd_st_ma(h_fwd_st_ma), .stall_cnt(h_stall_cnt)
    );

    typedef struct packed {
        logic       valid;
        logic [3:0] rs1, rs2, rs_st;
        logic       u1, u2, ust, wb;
        logic [3:0] rd;
        logic       ld;
    } instr_t;

    typedef struct {
        int         k;
        logic       stall, flush, hold, stma;
        logic [1:0] fa, fb, fo;
        int         cnt;
    } exp_t;

    exp_t   sb[$];
    instr_t mex[2], mma[2], mrw[2];
    int     mcnt[2];
    logic   mlu[2], mfl[2], mst[2];
    instr_t cur_of;
    logic   cur_busy;
    int     n_checks = 0;
    int     n_errors = 0;

    function automatic instr_t alu(int rd, int a, int b);
        instr_t i;
        i = '0; i.valid = 1; i.rs1 = 4'(a); i.rs2 = 4'(b); i.u1 = 1; i.u2 = 1; i.wb = 1; i.rd = 4'(rd);
        return i;
    endfunction

    function automatic instr_t ldi(int rd, int base);
        instr_t i;
        i = '0; i.valid = 1; i.rs1 = 4'(base); i.u1 = 1; i.wb = 1; i.rd = 4'(rd); i.ld = 1;
        return i;
    endfunction

    function automatic instr_t sti(int src, int base);
        instr_t i;
        i = '0; i.valid = 1; i.rs1 = 4'(base); i.u1 = 1; i.rs_st = 4'(src); i.ust = 1;
        return i;
    endfunction

    function automatic instr_t beq(int a, int b);
        instr_t i;
        i = alu(0, a, b); i.wb = 0;
        return i;
    endfunction

    function automatic instr_t nop();
        instr_t i;
        i = '0; i.valid = 1;
        return i;
    endfunction

    function automatic logic mt(int k, instr_t s, logic [3:0] r);
        return s.valid && s.wb && (s.rd == r) && !(k == 1 && r == 4'd0);
    endfunction

    function automatic logic [1:0] src(int k, logic u, logic [3:0] r);
        if (u && mt(k, mma[k], r) && !mma[k].ld) return 2'd1;
        if (u && mt(k, mrw[k], r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic compare(input exp_t e);
        if (e.k == 0) begin
            check("stall",  stall_front, e.stall); check("flush", flush_front, e.flush);
            check("hold",   hold_ex,     e.hold);  check("fwd_a", fwd_a_sel,   e.fa);
            check("fwd_b",  fwd_b_sel,   e.fb);    check("fwd_op2", fwd_op2_sel, e.fo);
            check("st_ma",  fwd_st_ma,   e.stma);  check("cnt",   stall_cnt,   e.cnt);
        end else begin
            check("h_stall", h_stall_front, e.stall); check("h_flush", h_flush_front, e.flush);
            check("h_hold",  h_hold_ex,     e.hold);  check("h_fwd_a", h_fwd_a_sel,   e.fa);
            check("h_fwd_b", h_fwd_b_sel,   e.fb);    check("h_fwd_op2", h_fwd_op2_sel, e.fo);
            check("h_st_ma", h_fwd_st_ma,   e.stma);  check("h_cnt",   h_stall_cnt,   e.cnt);
        end
    endtask

    // Drive one OF record plus control, queue expected outputs, compare on the falling edge.
    task automatic drive(input instr_t o, input logic busy, input logic br);
        exp_t e;
        logic lu, fl;
        of_valid = o.valid; of_rs1 = o.rs1; of_rs2 = o.rs2; of_rs_st = o.rs_st;
        of_uses1 = o.u1; of_uses2 = o.u2; of_uses_st = o.ust; of_wb = o.wb;
        of_rd = o.rd; of_is_ld = o.ld; ex_busy = busy; branch_taken = br;
        cur_of = o; cur_busy = busy;
        for (int k = 0; k < 2; k++) begin
            lu = o.valid && mex[k].ld && ((o.u1 && mt(k, mex[k], o.rs1)) || (o.u2 && mt(k, mex[k], o.rs2)));
            fl = !busy && mex[k].valid && br;
            e.k = k; e.hold = busy; e.flush = fl; e.stall = busy || (lu && !fl);
            e.fa = src(k, mex[k].u1, mex[k].rs1);
            e.fb = src(k, mex[k].u2, mex[k].rs2);
            e.fo = src(k, mex[k].ust, mex[k].rs_st);
            e.stma = mma[k].valid && mma[k].ust && mrw[k].ld && mt(k, mrw[k], mma[k].rs_st);
            e.cnt = mcnt[k];
            mlu[k] = lu; mfl[k] = fl; mst[k] = e.stall;
            if (mex[k].valid && mma[k].ld &&
                ((mex[k].u1 && mt(k, mma[k], mex[k].rs1)) || (mex[k].u2 && mt(k, mma[k], mex[k].rs2))))
                $error("load result consumed in EX before it exists (instance %0d)", k);
            sb.push_back(e);
        end
        @(negedge clk);
        while (sb.size() > 0) compare(sb.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            mrw[k] = mma[k];
            if (cur_busy) begin
                mma[k] = '0;
            end else begin
                mma[k] = mex[k];
                mex[k] = (mfl[k] || mlu[k] || !cur_of.valid) ? '0 : cur_of;
            end
            if (mst[k] && mcnt[k] < (k == 0 ? 65535 : 3)) mcnt[k]++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_stall", stall_front, 0); check("rst_hold", hold_ex, 0);
        check("rst_flush", flush_front, 0); check("rst_fa", fwd_a_sel, 0);
        check("rst_fb", fwd_b_sel, 0);      check("rst_fo", fwd_op2_sel, 0);
        check("rst_stma", fwd_st_ma, 0);    check("rst_cnt", stall_cnt, 0);
        check("rst_h_stall", h_stall_front, 0); check("rst_h_cnt", h_stall_cnt, 0);
        {of_valid, of_uses1, of_uses2, of_uses_st, of_wb, of_is_ld, ex_busy, branch_taken} = '0;
        {of_rs1, of_rs2, of_rs_st, of_rd} = '0;
        for (int k = 0; k < 2; k++) begin
            mex[k] = '0; mma[k] = '0; mrw[k] = '0; mcnt[k] = 0;
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        instr_t o, prev;
        logic   prev_stall;
        {of_valid, of_uses1, of_uses2, of_uses_st, of_wb, of_is_ld, ex_busy, branch_taken} = '0;
        {of_rs1, of_rs2, of_rs_st, of_rd} = '0;
        do_reset();

        // back-to-back RAW from MA, then one apart from RW
        drive(alu(1, 2, 3), 0, 0); tick();
        drive(alu(2, 1, 3), 0, 0); tick();
        drive(nop(), 0, 0); check("s1_fa_ma", fwd_a_sel, 1); check("s1_nostall", stall_front, 0); tick();
        drive(alu(1, 2, 3), 0, 0); tick();
        drive(nop(), 0, 0); tick();
        drive(alu(2, 1, 3), 0, 0); tick();
        drive(nop(), 0, 0); check("s1_fa_rw", fwd_a_sel, 2); tick();

        // load-use interlock
        do_reset();
        drive(ldi(4, 6), 0, 0); tick();
        drive(alu(5, 4, 4), 0, 0); check("s2_stall", stall_front, 1); tick();
        drive(alu(5, 4, 4), 0, 0); check("s2_release", stall_front, 0); tick();
        drive(nop(), 0, 0); check("s2_fa", fwd_a_sel, 2); check("s2_fb", fwd_b_sel, 2);
        check("s2_cnt", stall_cnt, 1); tick();

        // load then store of loaded data: no stall, MA patch
        do_reset();
        drive(ldi(4, 6), 0, 0); tick();
        drive(sti(4, 6), 0, 0); check("s3_nostall", stall_front, 0); tick();
        drive(nop(), 0, 0); check("s3_fo", fwd_op2_sel, 0); tick();
        drive(nop(), 0, 0); check("s3_st_ma", fwd_st_ma, 1); tick();

        // taken branch flushes the front
        do_reset();
        drive(beq(1, 2), 0, 0); tick();
        drive(ldi(4, 6), 0, 1); check("s4_flush", flush_front, 1); check("s4_stall", stall_front, 0); tick();
        drive(alu(5, 4, 4), 0, 0); check("s4_nostall", stall_front, 0); check("s4_cnt", stall_cnt, 0); tick();
        drive(nop(), 0, 1); check("s4_flush_nop", flush_front, 1); tick();

        // multi-cycle EX freeze
        do_reset();
        drive(alu(7, 1, 2), 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(alu(8, 7, 1), 1, 0); check("s5_stall", stall_front, 1); check("s5_hold", hold_ex, 1); tick();
        end
        drive(alu(8, 7, 1), 0, 0); check("s5_release", stall_front, 0); tick();
        drive(nop(), 0, 0); check("s5_fa", fwd_a_sel, 1); check("s5_cnt", stall_cnt, 5);
        check("s5_h_cnt_sat", h_stall_cnt, 3); tick();

        // reset while EX is busy
        do_reset();
        drive(alu(7, 1, 2), 0, 0); tick();
        drive(alu(8, 7, 1), 1, 0); tick();
        drive(alu(8, 7, 1), 1, 0);
        do_reset();

        // r0 hardwired in the second instance only
        drive(alu(0, 1, 2), 0, 0); tick();
        drive(alu(3, 0, 0), 0, 0); tick();
        drive(nop(), 0, 0); check("r0_h_fa", h_fwd_a_sel, 0); check("r0_h_fb", h_fwd_b_sel, 0);
        check("r0_fa", fwd_a_sel, 1); tick();
        drive(ldi(0, 6), 0, 0); tick();
        drive(alu(3, 0, 1), 0, 0); check("r0_h_nostall", h_stall_front, 0); check("r0_stall", stall_front, 1); tick();
        drive(nop(), 0, 0); tick();

        // random traffic; OF is held while the front is stalled
        do_reset();
        prev = nop(); prev_stall = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (prev_stall) begin
                o = prev;
            end else begin
                case ($urandom_range(0, 5))
                    0: o = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                    1: o = ldi($urandom_range(0, 3), $urandom_range(0, 3));
                    2: o = sti($urandom_range(0, 3), $urandom_range(0, 3));
                    3: o = beq($urandom_range(0, 3), $urandom_range(0, 3));
                    4: o = nop();
                    default: o = '0;
                endcase
            end
            drive(o, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            prev = o; prev_stall = mst[0];
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/simplerisc_hazard_unit.md
Name: simplerisc_hazard_unit

Overview:
- Pipeline-control block for the single-clock SimpleRISC core (IF, OF, EX, MA, RW).
- Keeps a scoreboard of the instructions in EX, MA and RW.
- Generates the operand-forwarding selects, the load-use interlock, the branch flush and the multi-cycle-EX freeze, plus a saturating stall counter.
- Sits beside the datapath; it drives only enables and mux selects and never carries data values.

Parameters:
- REG_ADDR_W, 4: register index width (16 registers).
- R0_HARDWIRED, 0: if 1, register 0 never matches for forwarding or stalls.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  single pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- of_valid  in  1  OF holds a real instruction.
- of_rs1  in  REG_ADDR_W  source A index. The decoder supplies 15 for ret.
- of_rs2  in  REG_ADDR_W  source B index.
- of_rs_st  in  REG_ADDR_W  store-data source index (instr[25:22] for st).
- of_uses1, of_uses2, of_uses_st  in  1 each  the corresponding source is read. of_uses2 is 0 for immediates.
- of_wb  in  1  writes a register.
- of_rd  in  REG_ADDR_W  destination. The decoder supplies 15 for call.
- of_is_ld  in  1  load.
- ex_busy  in  1  EX multi-cycle op (div/mod) not finished.
- branch_taken  in  1  instruction in EX resolves taken (including b, call, ret).
- stall_front  out  1  hold the IF and OF pipeline registers and the PC.
- flush_front  out  1  squash IF and OF contents (PC load from branch target).
- hold_ex  out  1  hold the EX pipeline register.
- fwd_a_sel, fwd_b_sel, fwd_op2_sel  out  2 each  EX operand source: 00 = OF-read value, 01 = EX_MA ALU result, 10 = MA_RW result.
- fwd_st_ma  out  1  MA store data taken from MA_RW load result.
- stall_cnt  out  CNT_W  cycles with stall_front=1.

Behaviour:
- Internal slots:
  - EX = {v, rs1, rs2, rs_st, uses1, uses2, uses_st, wb, rd, is_ld}.
  - MA = {v, wb, rd, is_ld, rs_st, uses_st}.
  - RW = {v, wb, rd, is_ld}.
- Reset (rst_n low, asynchronous): all slot v=0, stall_cnt=0. All outputs read 0 while rst_n=0. Reset mid-stall or mid-busy drops all state immediately.
- match(slot, r) = slot.v & slot.wb & slot.rd==r & !(R0_HARDWIRED & r==0).
- load_use = of_valid & EX.v & EX.is_ld & EX.wb & ((of_uses1 & of_rs1==EX.rd) | (of_uses2 & of_rs2==EX.rd)).
  - A store-data-only dependency (of_rs_st) never stalls.
- Combinational outputs, with priority ex_busy > branch > load_use:
  - hold_ex = ex_busy.
  - flush_front = !ex_busy & EX.v & branch_taken.
  - stall_front = ex_busy | (load_use & !flush_front).
- Slot update on each rising edge, in priority order:
  - ex_busy: EX holds; MA<=bubble; RW<=MA.
  - flush_front: EX<=bubble (OF instruction killed); MA<=EX; RW<=MA.
  - load_use: EX<=bubble; MA<=EX; RW<=MA.
  - otherwise: EX<=OF record (bubble if !of_valid); MA<=EX; RW<=MA.
- fwd_a_sel: 01 if EX.uses1 & match(MA, EX.rs1) & !MA.is_ld; else 10 if EX.uses1 & match(RW, EX.rs1); else 00. fwd_b_sel is identical using rs2/uses2.
  - An MA load matching A or B while EX.v=1 is illegal, since the interlock prevents it; the bench asserts this never occurs.
- fwd_op2_sel: same rule using rs_st/uses_st. An MA load match yields 00 (not a stall); the dependency is resolved one cycle later by fwd_st_ma.
- fwd_st_ma = MA.v & MA.uses_st & RW.is_ld & match(RW, MA.rs_st).
- Latency: all outputs are same-cycle combinational from the slots and OF inputs; the slots advance with one-cycle latency.
- Youngest producer wins: MA beats RW.
- The register file is write-first, so a producer three or more stages ahead needs no forwarding.
- stall_cnt increments on every cycle with stall_front=1 and saturates at all-ones (no wrap).

Test Plan:
- add r1 then add r2,r1,r3 back-to-back -> when the second add is in EX, fwd_a_sel=01; with a nop between them, fwd_a_sel=10; no stall.
- ld r4 then add r5,r4,r4 -> one cycle stall_front=1, EX bubble; the add then sees fwd_a_sel=fwd_b_sel=10; stall_cnt=1.
- ld r4 then st r4,[r6] -> no stall; in EX fwd_op2_sel=00; next cycle fwd_st_ma=1.
- beq taken in EX while a load-use pair sits in OF/IF -> flush_front=1, stall_front=0, EX slot bubble, stall_cnt unchanged.
- div with ex_busy high for 5 cycles while a dependent add waits in OF -> stall_front=hold_ex=1 for 5 cycles, MA gets bubbles, stall_cnt=5; forwarding correct after release.
- rst_n low during ex_busy -> all outputs 0 immediately. With R0_HARDWIRED=1, a write to r0 then a read of r0 -> fwd sel 00, no stall. With CNT_W=2, 5 stalls -> stall_cnt=3.
